// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the hazard scoreboard slice.
//   - FWD_* : forward-select codes (0 = register file, s = stage index s-1)
//   - sel_width() : width of one forward-select code for a given depth
//   - entry_t : one scoreboard entry {v, rd, ld}
// The rd field is sized for the widest supported register address
// (MAX_AW); narrower address widths are zero-extended into it.
// ---------------------------------------------------------------------------
package hazard_pkg;

    localparam int FWD_RF  = 0;
    localparam int FWD_EX  = 1;
    localparam int FWD_MEM = 2;
    localparam int FWD_WB  = 3;

    localparam int MAX_AW = 8;

    function automatic int sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic              v;
        logic [MAX_AW-1:0] rd;
        logic              ld;
    } entry_t;

endpackage

// File: rtl/hazard_match.sv
// ---------------------------------------------------------------------------
// hazard_match
// Per-operand youngest-match priority encoder with readiness check.
// Ports:
//   entries_i   : all tracked entries, index 0 = youngest (EX)
//   src_addr_i  : source register address of this operand
//   src_use_i   : operand is actually read
//   sel_o       : forward-select code (0 = register file)
//   not_ready_o : the winning producer cannot forward yet
// ---------------------------------------------------------------------------
module hazard_match
    import hazard_pkg::*;
#(
    parameter int AW         = 5,
    parameter int DEPTH      = 3,
    parameter int ALU_AVAIL  = 0,
    parameter int LOAD_AVAIL = 2,
    parameter int SELW       = sel_width(DEPTH)
) (
    input  entry_t [DEPTH-1:0] entries_i,
    input  logic   [AW-1:0]    src_addr_i,
    input  logic               src_use_i,
    output logic   [SELW-1:0]  sel_o,
    output logic               not_ready_o
);

    logic [MAX_AW-1:0] srcExt;
    logic              found;
    logic              winLd;
    int                winIdx;
    int                availIdx;

    assign srcExt = MAX_AW'(src_addr_i);

    // Scanning from oldest to youngest lets the youngest match overwrite any
    // older one, giving youngest-wins priority. Register 0 never matches.
    always_comb begin
        found       = 1'b0;
        winIdx      = 0;
        winLd       = 1'b0;
        availIdx    = 0;
        sel_o       = SELW'(FWD_RF);
        not_ready_o = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (entries_i[i].v && (entries_i[i].rd == srcExt) &&
                (srcExt != '0) && src_use_i) begin
                found  = 1'b1;
                winIdx = i;
                winLd  = entries_i[i].ld;
            end
        end
        availIdx = winLd ? LOAD_AVAIL : ALU_AVAIL;
        if (found) begin
            if (winIdx >= availIdx) begin
                sel_o = SELW'(winIdx + 1);
            end else begin
                not_ready_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// Shift-register scoreboard of in-flight register writes across DEPTH stages
// after decode; produces per-operand forward selects and a decode stall.
// Ports:
//   clk, rst (async, active low)
//   hold        : freeze all entries (stall still evaluated)
//   issue_*     : decode instruction valid / writes / is load / destination
//   kill        : squash the decode instruction (enters as bubble)
//   src_addr    : NSRC packed source addresses, operand k at [k*AW +: AW]
//   src_use     : operand k is read
//   fwd_sel     : NSRC packed forward-select codes
//   stall       : decode must hold
//   busy        : any tracked entry valid
//   stall_cnt   : saturating stall counter (only with HAZARD_STATS_EN)
// Optional feature macro: HAZARD_STATS_EN
// ---------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int AW         = 5,
    parameter int NSRC       = 2,
    parameter int DEPTH      = 3,
    parameter int ALU_AVAIL  = 0,
    parameter int LOAD_AVAIL = 2,
    parameter int SELW       = sel_width(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hold,
    input  logic                 issue_valid,
    input  logic                 issue_wen,
    input  logic                 issue_load,
    input  logic [AW-1:0]        issue_rd,
    input  logic                 kill,
    input  logic [NSRC*AW-1:0]   src_addr,
    input  logic [NSRC-1:0]      src_use,
    output logic [NSRC*SELW-1:0] fwd_sel,
    output logic                 stall,
    output logic                 busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]          stall_cnt
`endif
);

    entry_t [DEPTH-1:0] entry_q;
    entry_t [DEPTH-1:0] entry_d;
    entry_t             newEntry;
    logic   [NSRC-1:0]  opNotReady;

    for (genvar k = 0; k < NSRC; k++) begin : g_match
        hazard_match #(
            .AW         (AW),
            .DEPTH      (DEPTH),
            .ALU_AVAIL  (ALU_AVAIL),
            .LOAD_AVAIL (LOAD_AVAIL),
            .SELW       (SELW)
        ) u_match (
            .entries_i   (entry_q),
            .src_addr_i  (src_addr[k*AW +: AW]),
            .src_use_i   (src_use[k]),
            .sel_o       (fwd_sel[k*SELW +: SELW]),
            .not_ready_o (opNotReady[k])
        );
    end

    // A killed instruction never stalls decode, even if its operands are
    // not ready; it simply enters as a bubble.
    assign stall = issue_valid & ~kill & (|opNotReady);

    // A stalled, killed or register-0 write enters the pipe as a bubble.
    always_comb begin
        newEntry.v  = issue_valid & ~kill & ~stall & issue_wen & (issue_rd != '0);
        newEntry.rd = MAX_AW'(issue_rd);
        newEntry.ld = issue_load;
    end

    // Next-state: shift one place towards retirement unless held.
    always_comb begin
        entry_d = entry_q;
        if (!hold) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                entry_d[i] = entry_q[i-1];
            end
            entry_d[0] = newEntry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            busy = busy | entry_q[i].v;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    // Counts cycles that actually cost a decode slot; saturates at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !hold && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
